// File: rtl/pir_pkg.sv
// Shared definitions for the PIR motion-detection controller and the PIR
// sensor emulator: sample width, idle/threshold defaults, the one-hot state
// encoding and a saturating sample helper.
package pir_pkg;

  localparam int SAMPLE_W         = 7;
  localparam int DEFAULT_BASELINE = 10;
  // Motion threshold used by the controller; the emulator's default peaks
  // are chosen relative to it.
  localparam int MOTION_THRESHOLD = 50;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // One-hot, matching the controller's encoding style.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_RISE = 4'b0010,
    ST_HOLD = 4'b0100,
    ST_FALL = 4'b1000
  } pir_state_e;

  // Sums are formed on 8 bits so level + noise can never wrap; clamp to 127.
  function automatic logic [SAMPLE_W-1:0] sat127(input logic [7:0] v);
    return (v > 8'd127) ? 7'd127 : v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/pir_lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting left with feedback into bit 0.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset, loads SEED
//   advance - step the register by one position this cycle
//   value   - current register contents
module pir_lfsr8
  import pir_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_d   = advance ? {lfsr_q[6:0], feedback} : lfsr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the processes are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/pir_sensor_emulator.sv
// PIR sensor emulator: three 7-bit sample streams sitting at BASELINE (plus
// optional 0..3 LFSR noise) with programmable rise/hold/fall motion events.
// Samples update once per SAMPLE_DIV clocks.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   enable                - 0 freezes divider, FSM and outputs
//   trigger               - one-cycle request to start an event (IDLE only)
//   trigger_sel[2:0]      - channel mask for the event
//   peak_level[6:0]       - event peak, raised to BASELINE if lower
//   pir_sensor_1..3[6:0]  - sample streams
//   sample_strobe         - high in the cycle the sample outputs change
//   busy                  - event in progress
//   event_count[7:0]      - completed events, saturating
module pir_sensor_emulator
  import pir_pkg::*;
#(
  parameter int BASELINE   = DEFAULT_BASELINE,
  parameter int RAMP_STEP  = 5,
  parameter int HOLD_TICKS = 40,
  parameter int SAMPLE_DIV = 4,
  parameter bit NOISE_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                trigger,
  input  logic [2:0]          trigger_sel,
  input  logic [SAMPLE_W-1:0] peak_level,
  output logic [SAMPLE_W-1:0] pir_sensor_1,
  output logic [SAMPLE_W-1:0] pir_sensor_2,
  output logic [SAMPLE_W-1:0] pir_sensor_3,
  output logic                sample_strobe,
  output logic                busy,
  output logic [7:0]          event_count
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [7:0] BASE8     = 8'(BASELINE);
  localparam logic [7:0] STEP8     = 8'(RAMP_STEP);
  localparam logic [7:0] HOLD8     = 8'(HOLD_TICKS);
  // Any level above this still lands strictly above BASELINE after one step.
  localparam logic [7:0] FALL_MIN8 = 8'(BASELINE + RAMP_STEP);

  pir_state_e          state_q, state_d;
  logic [7:0]          level_q, level_d;
  logic [7:0]          peak_q, peak_d;
  logic [2:0]          sel_q, sel_d;
  logic [7:0]          hold_q, hold_d;
  logic [7:0]          events_q, events_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SAMPLE_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic                strobe_q;

  logic                tick;
  logic [7:0]          lfsr_value;
  logic [7:0]          noise;
  logic [7:0]          rise_sum;
  logic [SAMPLE_W-1:0] active_sample;
  logic [SAMPLE_W-1:0] idle_sample;
  logic                unused_lfsr_bits;

  assign tick = enable && (div_q == DIV_LAST);

  pir_lfsr8 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (tick),
    .value   (lfsr_value)
  );

  // Noise comes from the LFSR value held during the tick, before it steps.
  assign noise            = NOISE_EN ? {6'b0, lfsr_value[1:0]} : 8'd0;
  assign unused_lfsr_bits = ^lfsr_value[7:2];
  assign rise_sum         = level_q + STEP8;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    peak_d   = peak_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    events_d = events_q;
    div_d    = div_q;

    if (enable) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (enable && trigger && (trigger_sel != 3'b000)) begin
          sel_d   = trigger_sel;
          peak_d  = ({1'b0, peak_level} > BASE8) ? {1'b0, peak_level} : BASE8;
          state_d = ST_RISE;
        end
      end
      ST_RISE: begin
        if (tick) begin
          if (rise_sum >= peak_q) begin
            level_d = peak_q;
            hold_d  = 8'd0;
            state_d = ST_HOLD;
          end else begin
            level_d = rise_sum;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          hold_d = hold_q + 8'd1;
          if (hold_d == HOLD8) state_d = ST_FALL;
        end
      end
      ST_FALL: begin
        if (tick) begin
          if (level_q > FALL_MIN8) begin
            level_d = level_q - STEP8;
          end else begin
            level_d  = BASE8;
            state_d  = ST_IDLE;
            events_d = (events_q == 8'hFF) ? events_q : events_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs take the level being written on this tick, so they move together
  // with the FSM rather than one sample behind it.
  assign active_sample = sat127(level_d + noise);
  assign idle_sample   = sat127(BASE8 + noise);

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (tick) begin
      s1_d = sel_q[0] ? active_sample : idle_sample;
      s2_d = sel_q[1] ? active_sample : idle_sample;
      s3_d = sel_q[2] ? active_sample : idle_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      level_q  <= BASE8;
      peak_q   <= BASE8;
      sel_q    <= 3'b000;
      hold_q   <= 8'd0;
      events_q <= 8'd0;
      div_q    <= '0;
      s1_q     <= BASE8[SAMPLE_W-1:0];
      s2_q     <= BASE8[SAMPLE_W-1:0];
      s3_q     <= BASE8[SAMPLE_W-1:0];
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      peak_q   <= peak_d;
      sel_q    <= sel_d;
      hold_q   <= hold_d;
      events_q <= events_d;
      div_q    <= div_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      strobe_q <= tick;
    end
  end

  assign pir_sensor_1  = s1_q;
  assign pir_sensor_2  = s2_q;
  assign pir_sensor_3  = s3_q;
  assign sample_strobe = strobe_q;
  assign busy          = (state_q != ST_IDLE);
  assign event_count   = events_q;

endmodule

// File: doc/pir_sensor_emulator.md
Name: pir_sensor_emulator

Overview:
- Generates the three 7-bit PIR sample streams consumed by the motion-detection controller: a noisy baseline plus programmable motion events shaped rise/hold/fall.
- Used in simulation benches and as a self-test source on the FPGA, muxed in front of the real sensor inputs.
- Samples update on a divided tick that matches the controller's 4-cycle averaging cadence.

Parameters:
- BASELINE, 10, idle level on every channel (0..127).
- RAMP_STEP, 5, per-tick increment/decrement during rise/fall (1..127).
- HOLD_TICKS, 40, ticks spent at peak (1..255).
- SAMPLE_DIV, 4, clk cycles per sample tick (>=1).
- NOISE_EN, 1, 1 = add LFSR noise 0..3 to every output; 0 = deterministic.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = run; 0 = freeze tick divider, FSM and outputs
- trigger  in  1  single-cycle request to start a motion event
- trigger_sel  in  3  channel mask; bit0 = sensor 1, bit1 = sensor 2, bit2 = sensor 3
- peak_level  in  7  target peak for the event
- pir_sensor_1  out  7  sample stream, channel 1
- pir_sensor_2  out  7  sample stream, channel 2
- pir_sensor_3  out  7  sample stream, channel 3
- sample_strobe  out  1  1-cycle pulse in the cycle the outputs update
- busy  out  1  1 while state != IDLE
- event_count  out  8  completed events, saturates at 255

Behaviour:
- Reset (rst=1 at posedge clk):
  - state = IDLE; level = BASELINE; tick counter, hold counter and event_count = 0.
  - LFSR = 8'hA5; pir_sensor_1..3 = BASELINE; sample_strobe = 0; busy = 0.
  - Reset overrides everything, including mid-event; no event completion is counted.
- Tick:
  - div counter counts 0..SAMPLE_DIV-1 while enable=1.
  - tick = enable and div==SAMPLE_DIV-1.
  - sample_strobe registered = tick, so it is high in the same cycle the outputs change.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances on tick only; noise = lfsr[1:0] when NOISE_EN=1, else 0.
- FSM states IDLE, RISE, HOLD, FALL:
  - IDLE: trigger=1 and enable=1 and trigger_sel!=0 → latch sel and peak = max(peak_level, BASELINE); go to RISE on the next clk, busy=1. trigger with sel=0 is ignored.
  - RISE: on tick, level = min(level+RAMP_STEP, peak). When the new level equals peak, go to HOLD with the hold counter cleared.
  - HOLD: on tick, hold counter +1. When the count reaches HOLD_TICKS, go to FALL.
  - FALL: on tick, level = max(level-RAMP_STEP, BASELINE). When the new level equals BASELINE, go to IDLE and increment event_count (saturating).
- Peak equal to BASELINE: RISE completes on its first tick; the event still passes through HOLD and FALL and is counted.
- trigger while busy=1 is ignored; there is no queue. trigger in the cycle FALL→IDLE is also ignored.
- Output update, on tick only:
  - Selected channels = sat127(level + noise); unselected channels = sat127(BASELINE + noise).
  - Width rule: compute on 8 bits and clamp to 127.
- enable=0 mid-event: state, level, counters and outputs hold; resume exactly where frozen.
- Sensor inputs and latched sel/peak are not re-sampled during an event.

Decomposition:
- Shared package pir_pkg:
  - state encoding constants (one-hot 4-bit, same style as the controller);
  - SAMPLE_W=7;
  - default BASELINE/threshold values, with the threshold (50) shared by controller and emulator.
- One natural sub-module: pir_lfsr8 (clk, rst, advance, value[7:0]), reusable in other benches.

Test Plan (NOISE_EN=0, defaults unless stated):
- Reset: rst high 2 cycles → all outputs 10, busy=0, event_count=0, sample_strobe pulses every 4 cycles after release.
- Single event: trigger with sel=3'b010, peak=80 → sensor 2 steps 15,20,…,80 over 14 ticks, holds 40 ticks, falls to 10 in 14 ticks. Sensors 1/3 stay 10; event_count=1; busy high for the whole event.
- Busy rejection: second trigger (sel=3'b001) during HOLD → no change to sensor 1, event_count ends at 1.
- Clamping: peak=5 (below BASELINE) → single tick RISE, 40 ticks HOLD at 10, event counted. peak=127, RAMP_STEP=50 → levels 60,110,127.
- Freeze and reset: enable=0 for 20 cycles during RISE at level 40 → outputs stay 40, no strobes, then resume at 45. rst mid-FALL → outputs 10 next cycle, event_count unchanged.
- Noise: NOISE_EN=1, idle 256 ticks → every output in 10..13, LFSR sequence matches the reference model from seed 8'hA5.
